// File: rtl/exe_stage_pkg.sv
// Shared EXE-stage definitions: ID->EXE and EXE->MEM bus layouts, ALU op indices, divider FSM encoding.
package exe_stage_pkg;
   localparam int DS_ES_BUS_W = 153;
   localparam int ES_MS_BUS_W = 71;

   // ID->EXE bus field positions
   localparam int DS_ALU_OP_HI       = 152;
   localparam int DS_ALU_OP_LO       = 141;
   localparam int DS_DIV_EN_BIT      = 140;
   localparam int DS_DIV_SIGNED_BIT  = 139;
   localparam int DS_DIV_REM_BIT     = 138;
   localparam int DS_LOAD_OP_BIT     = 137;
   localparam int DS_SRC1_IS_PC_BIT  = 136;
   localparam int DS_SRC2_IS_IMM_BIT = 135;
   localparam int DS_GR_WE_BIT       = 134;
   localparam int DS_MEM_WE_BIT      = 133;
   localparam int DS_DEST_HI         = 132;
   localparam int DS_DEST_LO         = 128;
   localparam int DS_IMM_HI          = 127;
   localparam int DS_IMM_LO          = 96;
   localparam int DS_RJ_HI           = 95;
   localparam int DS_RJ_LO           = 64;
   localparam int DS_RKD_HI          = 63;
   localparam int DS_RKD_LO          = 32;
   localparam int DS_PC_HI           = 31;
   localparam int DS_PC_LO           = 0;

   // EXE->MEM bus field positions
   localparam int MS_LOAD_OP_BIT = 70;
   localparam int MS_GR_WE_BIT   = 69;
   localparam int MS_DEST_HI     = 68;
   localparam int MS_DEST_LO     = 64;
   localparam int MS_RESULT_HI   = 63;
   localparam int MS_RESULT_LO   = 32;
   localparam int MS_PC_HI       = 31;
   localparam int MS_PC_LO       = 0;

   // alu_op one-hot bit indices; lui passes through the decoder-formed immediate
   localparam int ALU_OP_W = 12;
   localparam int ALU_ADD  = 0;
   localparam int ALU_SUB  = 1;
   localparam int ALU_SLT  = 2;
   localparam int ALU_SLTU = 3;
   localparam int ALU_AND  = 4;
   localparam int ALU_NOR  = 5;
   localparam int ALU_OR   = 6;
   localparam int ALU_XOR  = 7;
   localparam int ALU_SLL  = 8;
   localparam int ALU_SRL  = 9;
   localparam int ALU_SRA  = 10;
   localparam int ALU_LUI  = 11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/exe_stage_div_unit.sv
// 32-cycle restoring divider on magnitudes; done marks the edge that completes the last iteration.
module div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        div_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);
   logic        running;
   logic [4:0]  iter;
   logic [31:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvs_q;
   logic        quo_neg;
   logic        rem_neg;
   logic        by_zero;
   logic        dvd_neg;
   logic        dvs_neg;
   logic [31:0] dvd_mag;
   logic [31:0] dvs_mag;
   logic [32:0] partial;
   logic [32:0] trial;

   assign dvd_neg = div_signed && dividend[31];
   assign dvs_neg = div_signed && divisor[31];
   assign dvd_mag = dvd_neg ? -dividend : dividend;
   assign dvs_mag = dvs_neg ? -divisor : divisor;

   // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
   assign partial = {rem_q, quo_q[31]};
   assign trial   = partial - {1'b0, dvs_q};
   assign done    = running && (iter == 5'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         running <= 1'b0;
         iter    <= 5'd0;
      end else if (start) begin
         running <= 1'b1;
         iter    <= 5'd0;
      end else if (running) begin
         iter <= iter + 5'd1;
         if (iter == 5'd31)
            running <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         rem_q   <= 32'd0;
         quo_q   <= dvd_mag;
         dvs_q   <= dvs_mag;
         quo_neg <= dvd_neg ^ dvs_neg;
         rem_neg <= dvd_neg;
         by_zero <= (divisor == 32'd0);
      end else if (running) begin
         rem_q <= trial[32] ? partial[31:0] : trial[31:0];
         quo_q <= {quo_q[30:0], ~trial[32]};
      end
   end

   // divide-by-zero leaves |dividend| in rem_q, so the remainder sign fix already yields rj
   assign quotient  = by_zero ? 32'hFFFF_FFFF : (quo_neg ? -quo_q : quo_q);
   assign remainder = rem_neg ? -rem_q : rem_q;
endmodule

// File: rtl/exe_stage.sv
// EXE pipeline stage: inline ALU, memory request, forwarding; define EXE_DIV_EN for the 34-cycle divider.
module exe_stage
   import exe_stage_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ms_allowin,
   output logic                   es_allowin,
   input  logic                   ds_to_es_valid,
   input  logic [DS_ES_BUS_W-1:0] ds_to_es_bus,
   output logic                   es_to_ms_valid,
   output logic [ES_MS_BUS_W-1:0] es_to_ms_bus,
   output logic                   data_sram_en,
   output logic [3:0]             data_sram_we,
   output logic [31:0]            data_sram_addr,
   output logic [31:0]            data_sram_wdata,
   output logic [4:0]             es_to_ds_dest,
   output logic [31:0]            es_to_ds_value,
   output logic                   es_to_ds_load
);
   logic                   es_valid;
   logic                   es_ready_go;
   logic [DS_ES_BUS_W-1:0] es_bus;
   logic [ALU_OP_W-1:0]    alu_op;
   logic                   load_op;
   logic                   src1_is_pc;
   logic                   src2_is_imm;
   logic                   gr_we;
   logic                   mem_we;
   logic [4:0]             dest;
   logic [31:0]            imm;
   logic [31:0]            rj_value;
   logic [31:0]            rkd_value;
   logic [31:0]            pc;
   logic [31:0]            alu_src1;
   logic [31:0]            alu_src2;
   logic [4:0]             sa;
   logic [31:0]            add_sum;
   logic [31:0]            sub_res;
   logic [31:0]            alu_result;
   logic [31:0]            es_result;

   assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
   assign es_to_ms_valid = es_valid && es_ready_go;

   always_ff @(posedge clk) begin
      if (reset)
         es_valid <= 1'b0;
      else if (es_allowin)
         es_valid <= ds_to_es_valid;
   end

   always_ff @(posedge clk) begin
      if (ds_to_es_valid && es_allowin)
         es_bus <= ds_to_es_bus;
   end

   assign alu_op      = es_bus[DS_ALU_OP_HI:DS_ALU_OP_LO];
   assign load_op     = es_bus[DS_LOAD_OP_BIT];
   assign src1_is_pc  = es_bus[DS_SRC1_IS_PC_BIT];
   assign src2_is_imm = es_bus[DS_SRC2_IS_IMM_BIT];
   assign gr_we       = es_bus[DS_GR_WE_BIT];
   assign mem_we      = es_bus[DS_MEM_WE_BIT];
   assign dest        = es_bus[DS_DEST_HI:DS_DEST_LO];
   assign imm         = es_bus[DS_IMM_HI:DS_IMM_LO];
   assign rj_value    = es_bus[DS_RJ_HI:DS_RJ_LO];
   assign rkd_value   = es_bus[DS_RKD_HI:DS_RKD_LO];
   assign pc          = es_bus[DS_PC_HI:DS_PC_LO];

   assign alu_src1 = src1_is_pc  ? pc  : rj_value;
   assign alu_src2 = src2_is_imm ? imm : rkd_value;
   assign sa       = alu_src2[4:0];
   assign add_sum  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;

   assign alu_result =
        ({32{alu_op[ALU_ADD]}}  & add_sum)
      | ({32{alu_op[ALU_SUB]}}  & sub_res)
      | ({32{alu_op[ALU_SLT]}}  & {31'd0, $signed(alu_src1) < $signed(alu_src2)})
      | ({32{alu_op[ALU_SLTU]}} & {31'd0, alu_src1 < alu_src2})
      | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
      | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
      | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
      | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
      | ({32{alu_op[ALU_SLL]}}  & (alu_src1 << sa))
      | ({32{alu_op[ALU_SRL]}}  & (alu_src1 >> sa))
      | ({32{alu_op[ALU_SRA]}}  & 32'($signed(alu_src1) >>> sa))
      | ({32{alu_op[ALU_LUI]}}  & alu_src2);

`ifdef EXE_DIV_EN
   div_state_t  div_state;
   div_state_t  div_next;
   logic        div_en;
   logic        div_signed;
   logic        div_rem;
   logic        div_start;
   logic        div_done;
   logic [31:0] div_quotient;
   logic [31:0] div_remainder;

   assign div_en     = es_bus[DS_DIV_EN_BIT];
   assign div_signed = es_bus[DS_DIV_SIGNED_BIT];
   assign div_rem    = es_bus[DS_DIV_REM_BIT];

   always_ff @(posedge clk) begin
      if (reset)
         div_state <= DIV_IDLE;
      else
         div_state <= div_next;
   end

   always_comb begin
      div_next = div_state;
      unique case (div_state)
         DIV_IDLE: if (es_valid && div_en)              div_next = DIV_BUSY;
         DIV_BUSY: if (div_done)                        div_next = DIV_DONE;
         DIV_DONE: if (es_to_ms_valid && ms_allowin)    div_next = DIV_IDLE;
         default:                                       div_next = DIV_IDLE;
      endcase
   end

   always_comb begin
      div_start   = (div_state == DIV_IDLE) && es_valid && div_en;
      es_ready_go = !div_en || (div_state == DIV_DONE);
   end

   div_unit u_div (
      .clk        (clk),
      .reset      (reset),
      .start      (div_start),
      .div_signed (div_signed),
      .dividend   (rj_value),
      .divisor    (rkd_value),
      .done       (div_done),
      .quotient   (div_quotient),
      .remainder  (div_remainder)
   );

   assign es_result = div_en ? (div_rem ? div_remainder : div_quotient) : alu_result;
`else
   logic unused_div_fields;

   assign es_ready_go       = 1'b1;
   assign es_result         = alu_result;
   assign unused_div_fields = ^{es_bus[DS_DIV_EN_BIT], es_bus[DS_DIV_SIGNED_BIT], es_bus[DS_DIV_REM_BIT]};
`endif

   assign es_to_ms_bus[MS_LOAD_OP_BIT]            = load_op;
   assign es_to_ms_bus[MS_GR_WE_BIT]              = gr_we;
   assign es_to_ms_bus[MS_DEST_HI:MS_DEST_LO]     = dest;
   assign es_to_ms_bus[MS_RESULT_HI:MS_RESULT_LO] = es_result;
   assign es_to_ms_bus[MS_PC_HI:MS_PC_LO]         = pc;

   // stores may repeat while held in EXE; rewriting the same word is harmless
   assign data_sram_en    = es_valid && (load_op || mem_we);
   assign data_sram_we    = {4{es_valid && mem_we}};
   assign data_sram_addr  = add_sum;
   assign data_sram_wdata = rkd_value;

   assign es_to_ds_dest  = (es_valid && gr_we) ? dest : 5'd0;
   assign es_to_ds_value = (es_valid && gr_we) ? es_result : 32'd0;
   assign es_to_ds_load  = es_valid && load_op;
endmodule
